// File: rtl/proc_mem_arbiter_pkg.sv
// Shared definitions for the processor memory arbiter: request type encoding and the
// arbiter FSM state.
package proc_mem_arbiter_pkg;

   localparam logic MEM_REQ_READ  = 1'b0;
   localparam logic MEM_REQ_WRITE = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWaitI = 2'd1,
      StWaitD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/proc_mem_arb_starve_ctr.sv
// Saturating fetch-starvation counter: counts dmem grants taken while a fetch waits,
// saturates at LIMIT and is cleared when the fetch is finally granted.
module proc_mem_arb_starve_ctr #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   logic [3:0] cnt_q, cnt_d;

   assign at_limit_o = (cnt_q == 4'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (inc_i && !at_limit_o) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch (imem) and data (dmem) ports,
// one transaction in flight. Define PROC_MEM_ARB_PERF_EN to add grant counters.
module proc_mem_arbiter
   import proc_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
`ifdef PROC_MEM_ARB_PERF_EN
   output logic [31:0]       imem_grant_cnt,
   output logic [31:0]       dmem_grant_cnt,
   output logic [31:0]       starve_force_cnt,
`endif
   input  logic              clk,
   input  logic              rst,
   input  logic              imemreq_val,
   input  logic [ADDR_W-1:0] imemreq_addr,
   output logic              imemreq_rdy,
   output logic              imemresp_val,
   output logic [DATA_W-1:0] imemresp_data,
   input  logic              dmemreq_val,
   input  logic              dmemreq_type,
   input  logic [ADDR_W-1:0] dmemreq_addr,
   input  logic [DATA_W-1:0] dmemreq_wdata,
   output logic              dmemreq_rdy,
   output logic              dmemresp_val,
   output logic [DATA_W-1:0] dmemresp_data,
   output logic              memreq_val,
   output logic              memreq_type,
   output logic [ADDR_W-1:0] memreq_addr,
   output logic [DATA_W-1:0] memreq_wdata,
   input  logic              memreq_rdy,
   input  logic              memresp_val,
   input  logic [DATA_W-1:0] memresp_data
);

   arb_state_e state_q, state_d;
   logic       type_q, type_d;
   logic       in_idle, at_limit;
   logic       dmem_gnt, imem_gnt;
   logic       ifire, dfire;

   // Outputs are forced quiet while reset is held, whatever the state register holds.
   assign in_idle  = (state_q == StIdle) && !rst;
   assign dmem_gnt = in_idle && dmemreq_val && !(imemreq_val && at_limit);
   assign imem_gnt = in_idle && imemreq_val && !dmem_gnt;
   assign dfire    = dmemreq_val && dmemreq_rdy;
   assign ifire    = imemreq_val && imemreq_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         type_q  <= MEM_REQ_READ;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (dfire) begin
               state_d = StWaitD;
            end else if (ifire) begin
               state_d = StWaitI;
            end
         end
         StWaitI, StWaitD: begin
            if (memresp_val) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign type_d = dfire ? dmemreq_type : type_q;

   always_comb begin
      memreq_val    = dmem_gnt || imem_gnt;
      memreq_type   = MEM_REQ_READ;
      memreq_addr   = '0;
      memreq_wdata  = '0;
      dmemreq_rdy   = memreq_rdy && dmem_gnt;
      imemreq_rdy   = memreq_rdy && imem_gnt;
      imemresp_val  = 1'b0;
      imemresp_data = '0;
      dmemresp_val  = 1'b0;
      dmemresp_data = '0;
      if (dmem_gnt) begin
         memreq_type  = dmemreq_type;
         memreq_addr  = dmemreq_addr;
         memreq_wdata = dmemreq_wdata;
      end else if (imem_gnt) begin
         memreq_addr  = imemreq_addr;
      end
      if (!rst && memresp_val) begin
         case (state_q)
            StWaitI: begin
               imemresp_val  = 1'b1;
               imemresp_data = memresp_data;
            end
            StWaitD: begin
               dmemresp_val  = 1'b1;
               dmemresp_data = (type_q == MEM_REQ_WRITE) ? '0 : memresp_data;
            end
            default: ;
         endcase
      end
   end

   proc_mem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (dfire && imemreq_val),
      .clr_i      (ifire),
      .at_limit_o (at_limit)
   );

`ifdef PROC_MEM_ARB_PERF_EN
   logic [31:0] imem_cnt_q, dmem_cnt_q, force_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_cnt_q  <= '0;
         dmem_cnt_q  <= '0;
         force_cnt_q <= '0;
      end else begin
         if (ifire) imem_cnt_q <= imem_cnt_q + 32'd1;
         if (dfire) dmem_cnt_q <= dmem_cnt_q + 32'd1;
         // Forced means the fetch only won because the limit overrode a pending dmem.
         if (ifire && at_limit && dmemreq_val) force_cnt_q <= force_cnt_q + 32'd1;
      end
   end

   assign imem_grant_cnt   = imem_cnt_q;
   assign dmem_grant_cnt   = dmem_cnt_q;
   assign starve_force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Scoreboard bench for proc_mem_arbiter: requester and memory models drive the DUT on the
// falling edge, expected responses are queued at request acceptance and checked on output.
module tb_proc_mem_arbiter;

   localparam int unsigned SL = 4;

   typedef struct packed {
      logic        typ;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imemreq_val = 1'b0, imemreq_rdy, imemresp_val;
   logic [31:0] imemreq_addr = '0, imemresp_data;
   logic        dmemreq_val = 1'b0, dmemreq_type = 1'b0, dmemreq_rdy, dmemresp_val;
   logic [31:0] dmemreq_addr = '0, dmemreq_wdata = '0, dmemresp_data;
   logic        memreq_val, memreq_type, memreq_rdy = 1'b1, memresp_val = 1'b0;
   logic [31:0] memreq_addr, memreq_wdata, memresp_data = '0;
`ifdef PROC_MEM_ARB_PERF_EN
   logic [31:0] imem_grant_cnt, dmem_grant_cnt, starve_force_cnt;
`endif

   always #5 clk = ~clk;

   proc_mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (SL)
   ) dut (
`ifdef PROC_MEM_ARB_PERF_EN
      .imem_grant_cnt   (imem_grant_cnt),
      .dmem_grant_cnt   (dmem_grant_cnt),
      .starve_force_cnt (starve_force_cnt),
`endif
      .clk           (clk),
      .rst           (rst),
      .imemreq_val   (imemreq_val),
      .imemreq_addr  (imemreq_addr),
      .imemreq_rdy   (imemreq_rdy),
      .imemresp_val  (imemresp_val),
      .imemresp_data (imemresp_data),
      .dmemreq_val   (dmemreq_val),
      .dmemreq_type  (dmemreq_type),
      .dmemreq_addr  (dmemreq_addr),
      .dmemreq_wdata (dmemreq_wdata),
      .dmemreq_rdy   (dmemreq_rdy),
      .dmemresp_val  (dmemresp_val),
      .dmemresp_data (dmemresp_data),
      .memreq_val    (memreq_val),
      .memreq_type   (memreq_type),
      .memreq_addr   (memreq_addr),
      .memreq_wdata  (memreq_wdata),
      .memreq_rdy    (memreq_rdy),
      .memresp_val   (memresp_val),
      .memresp_data  (memresp_data)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] i_q[$];
   dreq_t       d_q[$];
   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];
   bit          grant_log[$];
   int          lat = 1;
   int          cd = 0;
   int          rdy_low = 0;
   logic [31:0] pend_data = '0;
   int          irdy_n = 0, iresp_n = 0, dresp_n = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a ^ 32'h00A0_0093;
   endfunction

   function automatic bit all_idle();
      return (i_q.size() == 0) && (d_q.size() == 0) && (exp_i.size() == 0) &&
             (exp_d.size() == 0) && (cd == 0);
   endfunction

   // One clock cycle: drive on the falling edge, then observe 1 ns later.
   task automatic step(input logic r);
      dreq_t cur;
      @(negedge clk);
      rst          = r;
      imemreq_val  = (i_q.size() > 0);
      imemreq_addr = imemreq_val ? i_q[0] : 32'd0;
      dmemreq_val  = (d_q.size() > 0);
      cur          = dmemreq_val ? d_q[0] : '0;
      dmemreq_type  = cur.typ;
      dmemreq_addr  = cur.addr;
      dmemreq_wdata = cur.wdata;
      memreq_rdy   = (rdy_low == 0);
      if (rdy_low > 0) rdy_low--;
      memresp_val  = 1'b0;
      memresp_data = $urandom();
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            memresp_val  = 1'b1;
            memresp_data = pend_data;
         end
      end
      #1;
      if (rst) begin
         check("rst_memreq_val", 32'(memreq_val), 32'd0);
         check("rst_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
         check("rst_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
         check("rst_imemresp_val", 32'(imemresp_val), 32'd0);
         check("rst_dmemresp_val", 32'(dmemresp_val), 32'd0);
      end else begin
         irdy_n  += int'(imemreq_rdy);
         iresp_n += int'(imemresp_val);
         dresp_n += int'(dmemresp_val);
         if (exp_i.size() == 0) check("imemresp_spurious", 32'(imemresp_val), 32'd0);
         else if (imemresp_val) check("imemresp_data", imemresp_data, exp_i.pop_front());
         if (exp_d.size() == 0) check("dmemresp_spurious", 32'(dmemresp_val), 32'd0);
         else if (dmemresp_val) check("dmemresp_data", dmemresp_data, exp_d.pop_front());
         if (memreq_val && memreq_rdy) begin
            pend_data = memreq_type ? 32'hFFFF_FFFF : memfn(memreq_addr);
            cd = lat;
         end
         if (dmemreq_val && dmemreq_rdy) begin
            cur = d_q.pop_front();
            check("memreq_val_d", 32'(memreq_val), 32'd1);
            check("memreq_type_d", 32'(memreq_type), 32'(cur.typ));
            check("memreq_addr_d", memreq_addr, cur.addr);
            if (cur.typ) check("memreq_wdata", memreq_wdata, cur.wdata);
            exp_d.push_back(cur.typ ? 32'd0 : memfn(cur.addr));
            grant_log.push_back(1'b1);
         end
         if (imemreq_val && imemreq_rdy) begin
            check("memreq_val_i", 32'(memreq_val), 32'd1);
            check("memreq_type_i", 32'(memreq_type), 32'd0);
            check("memreq_addr_i", memreq_addr, i_q[0]);
            exp_i.push_back(memfn(i_q.pop_front()));
            grant_log.push_back(1'b0);
         end
      end
   endtask

   task automatic run_until_idle(input int budget);
      for (int c = 0; c < budget && !all_idle(); c++) step(1'b0);
      check("phase_done", 32'(all_idle()), 32'd1);
   endtask

   // pat holds the expected grant order MSB first, 1 = dmem, 0 = imem.
   task automatic check_log(input logic [15:0] pat, input int n);
      check("grant_count", 32'(grant_log.size()), 32'(n));
      for (int i = 0; i < n && i < grant_log.size(); i++)
         check("grant_order", 32'(grant_log[i]), 32'(pat[n-1-i]));
      grant_log.delete();
   endtask

   initial begin
      // Reset with both requesters waiting and a stray memory response landing in reset.
      i_q.push_back(32'h0000_0004);
      d_q.push_back('{typ: 1'b0, addr: 32'h0000_0040, wdata: 32'd0});
      pend_data = 32'h1234_5678;
      cd = 2;
      repeat (3) step(1'b1);
      lat = 1;
      run_until_idle(50);
      check_log(16'b10, 2);

      // Fetch only, 3-cycle memory latency.
      irdy_n = 0; iresp_n = 0; dresp_n = 0;
      lat = 3;
      i_q.push_back(32'h0000_0000);
      run_until_idle(50);
      check("fetch_rdy_pulses", 32'(irdy_n), 32'd1);
      check("fetch_resp_pulses", 32'(iresp_n), 32'd1);
      check("fetch_no_dresp", 32'(dresp_n), 32'd0);
      grant_log.delete();

      // Starvation: dmem keeps winning until the limit forces a fetch through.
      lat = 1;
      for (int k = 0; k < 6; k++)
         d_q.push_back('{typ: 1'b0, addr: 32'h0000_1000 + 32'(k * 4), wdata: 32'd0});
      i_q.push_back(32'h0000_0800);
      i_q.push_back(32'h0000_0804);
      run_until_idle(200);
      check_log(16'b11110110, 8);

      // Store ack returns zero data, then a load shows the type latch follows.
      lat = 2;
      d_q.push_back('{typ: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF});
      d_q.push_back('{typ: 1'b0, addr: 32'h0000_0104, wdata: 32'hCAFE_F00D});
      run_until_idle(50);
      check_log(16'b11, 2);

      // Memory back-pressure: request must hold steady while memreq_rdy is low.
      irdy_n = 0;
      rdy_low = 5;
      i_q.push_back(32'h0000_0200);
      repeat (5) begin
         step(1'b0);
         check("stall_memreq_val", 32'(memreq_val), 32'd1);
         check("stall_memreq_addr", memreq_addr, 32'h0000_0200);
         check("stall_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
      end
      run_until_idle(50);
      check("stall_rdy_pulses", 32'(irdy_n), 32'd1);
      grant_log.delete();

      // Reset while waiting on a load; the late response must be dropped.
      lat = 4;
      d_q.push_back('{typ: 1'b0, addr: 32'h0000_0300, wdata: 32'd0});
      for (int c = 0; c < 20 && d_q.size() > 0; c++) step(1'b0);
      check("rst_test_dfire", 32'(d_q.size()), 32'd0);
      step(1'b0);
      step(1'b1);
      exp_d.delete();
      dresp_n = 0;
      repeat (4) step(1'b0);
      check("rst_drop_dresp", 32'(dresp_n), 32'd0);
      check("rst_idle_no_req", 32'(memreq_val), 32'd0);
      irdy_n = 0; iresp_n = 0;
      lat = 1;
      i_q.push_back(32'h0000_0400);
      run_until_idle(50);
      check("post_rst_fetch_rdy", 32'(irdy_n), 32'd1);
      check("post_rst_fetch_resp", 32'(iresp_n), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
